// File: rtl/vgachargen_console_writer_if.sv
// Byte-stream input and char_map write bus of the vgachargen console writer.
// VGACON_COLOR_EN adds the colour input and the col_map write bus.
interface vgachargen_console_writer_if #(
    parameter int ADDR_W = 10,
    parameter int COL_W  = 7,
    parameter int ROW_W  = 5
);
    logic              char_valid_i;
    logic              char_ready_o;
    logic [7:0]        char_data_i;
    logic [ADDR_W-1:0] char_map_addr_o;
    logic              char_map_we_o;
    logic [3:0]        char_map_be_o;
    logic [31:0]       char_map_wdata_o;
    logic              busy_o;
    logic [COL_W-1:0]  cursor_col_o;
    logic [ROW_W-1:0]  cursor_row_o;
`ifdef VGACON_COLOR_EN
    logic [7:0]        color_i;
    logic [ADDR_W-1:0] col_map_addr_o;
    logic              col_map_we_o;
    logic [3:0]        col_map_be_o;
    logic [31:0]       col_map_wdata_o;
`endif

    // slave: the console writer itself; master: the byte feeder / map consumer
    modport slave (
        input  char_valid_i, char_data_i,
`ifdef VGACON_COLOR_EN
        input  color_i,
        output col_map_addr_o, col_map_we_o, col_map_be_o, col_map_wdata_o,
`endif
        output char_ready_o, char_map_addr_o, char_map_we_o, char_map_be_o,
        output char_map_wdata_o, busy_o, cursor_col_o, cursor_row_o
    );

    modport master (
        output char_valid_i, char_data_i,
`ifdef VGACON_COLOR_EN
        output color_i,
        input  col_map_addr_o, col_map_we_o, col_map_be_o, col_map_wdata_o,
`endif
        input  char_ready_o, char_map_addr_o, char_map_we_o, char_map_be_o,
        input  char_map_wdata_o, busy_o, cursor_col_o, cursor_row_o
    );
endinterface

// File: rtl/vgachargen_console_writer.sv
// Text-cursor console feeding the vgachargen char_map write port (CR/LF/BS/FF).
// Define VGACON_COLOR_EN to also drive the colour map in lockstep.
module vgachargen_console_writer #(
    parameter int         COLS      = 80,
    parameter int         ROWS      = 30,
    parameter int         ADDR_W    = 10,
    parameter logic [7:0] FILL_CHAR = 8'h20,
    parameter logic [7:0] DEF_COLOR = 8'h0F
) (
    input  logic clk_i,
    input  logic rst_i,
    vgachargen_console_writer_if.slave bus
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int IDX_W = ADDR_W + 2;
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(COLS * ROWS / 4 - 1);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

    state_t            state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              busy;

    logic              accept;
    logic              printable;
    logic [7:0]        din;
    logic [IDX_W-1:0]  idx;
    logic [ROW_W-1:0]  row_inc;

    assign din       = bus.char_data_i;
    assign bus.char_ready_o = (state == IDLE) && !rst_i;
    assign accept    = bus.char_valid_i && bus.char_ready_o;
    assign printable = din[7] || ((din >= 8'h20) && (din <= 8'h7E));
    // constant multiply: synthesises to a short shift-add tree
    assign idx       = IDX_W'(row) * IDX_W'(COLS) + IDX_W'(col);
    assign row_inc   = (row == ROW_W'(ROWS - 1)) ? '0 : row + 1'b1;

`ifdef VGACON_COLOR_EN
    logic [31:0] cwdata;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
            addr  <= '0;
            we    <= 1'b0;
            be    <= '0;
            wdata <= '0;
            busy  <= 1'b0;
`ifdef VGACON_COLOR_EN
            cwdata <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    we <= 1'b0;
                    if (accept) begin
                        if (printable) begin
                            state <= WRITE;
                            we    <= 1'b1;
                            addr  <= idx[IDX_W-1:2];
                            be    <= 4'b0001 << idx[1:0];
                            wdata <= {4{din}};
`ifdef VGACON_COLOR_EN
                            cwdata <= {4{bus.color_i}};
`endif
                            if (col == COL_W'(COLS - 1)) begin
                                col <= '0;
                                row <= row_inc;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end else begin
                            case (din)
                                8'h0D: col <= '0;
                                8'h0A: begin
                                    col <= '0;
                                    row <= row_inc;
                                end
                                8'h08: if (col != '0) col <= col - 1'b1;
                                8'h0C: begin
                                    state <= CLEAR;
                                    busy  <= 1'b1;
                                    col   <= '0;
                                    row   <= '0;
                                    we    <= 1'b1;
                                    addr  <= '0;
                                    be    <= 4'hF;
                                    wdata <= {4{FILL_CHAR}};
`ifdef VGACON_COLOR_EN
                                    cwdata <= {4{DEF_COLOR}};
`endif
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                WRITE: begin
                    state <= IDLE;
                    we    <= 1'b0;
                end
                CLEAR: begin
                    if (addr == LAST_WORD) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        we    <= 1'b0;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    we    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.char_map_addr_o  = addr;
    assign bus.char_map_we_o    = we;
    assign bus.char_map_be_o    = be;
    assign bus.char_map_wdata_o = wdata;
    assign bus.busy_o           = busy;
    assign bus.cursor_col_o     = col;
    assign bus.cursor_row_o     = row;

`ifdef VGACON_COLOR_EN
    assign bus.col_map_addr_o  = addr;
    assign bus.col_map_we_o    = we;
    assign bus.col_map_be_o    = be;
    assign bus.col_map_wdata_o = cwdata;
`else
    // colour is not stored in this build
    logic unused_color;
    assign unused_color = ^DEF_COLOR;
`endif
endmodule

// File: tb/tb_vgachargen_console_writer.sv
// Scoreboard bench: stimulus queues expected map writes, a monitor checks each write.
module tb_vgachargen_console_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vgachargen_console_writer_if #(.ADDR_W(10), .COL_W(7), .ROW_W(5)) bus ();

    vgachargen_console_writer dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] cdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    localparam logic [7:0] TB_COLOR = 8'h1E;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [9:0] a, input logic [3:0] be, input logic [7:0] ch,
                        input logic [7:0] co);
        exp_t e;
        e.addr = a; e.be = be; e.wdata = {4{ch}}; e.cdata = {4{co}};
        exp_q.push_back(e);
    endtask

    // Printable char at linear index idx
    task automatic push_idx(input int idx, input logic [7:0] ch);
        push(10'(idx / 4), 4'b0001 << (idx % 4), ch, TB_COLOR);
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bus.char_data_i  = b;
        bus.char_valid_i = 1'b1;
        while (!bus.char_ready_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.char_ready_o) begin
            checks++; errors++;
            $display("FAIL send_timeout: byte %0h not accepted", b);
            bus.char_valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.char_valid_i = 1'b0;
    endtask

    // Monitor: every write strobe must match the head of the scoreboard
    always @(negedge clk) begin
`ifdef VGACON_COLOR_EN
        chk("col_we_lockstep", 32'(bus.col_map_we_o), 32'(bus.char_map_we_o));
`endif
        if (bus.char_map_we_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %0d be %0h wdata %0h",
                         bus.char_map_addr_o, bus.char_map_be_o, bus.char_map_wdata_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.char_map_addr_o !== e.addr || bus.char_map_be_o !== e.be ||
                    bus.char_map_wdata_o !== e.wdata) begin
                    errors++;
                    $display("FAIL write: got addr %0d be %0h wdata %0h want addr %0d be %0h wdata %0h",
                             bus.char_map_addr_o, bus.char_map_be_o, bus.char_map_wdata_o,
                             e.addr, e.be, e.wdata);
                end
`ifdef VGACON_COLOR_EN
                if (bus.col_map_addr_o !== e.addr || bus.col_map_be_o !== e.be ||
                    bus.col_map_wdata_o !== e.cdata) begin
                    errors++;
                    $display("FAIL col_write: got addr %0d be %0h wdata %0h want wdata %0h",
                             bus.col_map_addr_o, bus.col_map_be_o, bus.col_map_wdata_o, e.cdata);
                end
`endif
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we"},    32'(bus.char_map_we_o), 0);
        chk({tag, "_addr"},  32'(bus.char_map_addr_o), 0);
        chk({tag, "_be"},    32'(bus.char_map_be_o), 0);
        chk({tag, "_wdata"}, bus.char_map_wdata_o, 0);
        chk({tag, "_busy"},  32'(bus.busy_o), 0);
        chk({tag, "_ready"}, 32'(bus.char_ready_o), 0);
        chk({tag, "_col"},   32'(bus.cursor_col_o), 0);
        chk({tag, "_row"},   32'(bus.cursor_row_o), 0);
`ifdef VGACON_COLOR_EN
        chk({tag, "_cwe"},   32'(bus.col_map_we_o), 0);
        chk({tag, "_caddr"}, 32'(bus.col_map_addr_o), 0);
        chk({tag, "_cbe"},   32'(bus.col_map_be_o), 0);
        chk({tag, "_cwdata"}, bus.col_map_wdata_o, 0);
`endif
    endtask

    initial begin
        int cnt;
        string s;
        bus.char_valid_i = 1'b0;
        bus.char_data_i  = 8'h00;
`ifdef VGACON_COLOR_EN
        bus.color_i = TB_COLOR;
`endif
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("reset");
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);

        // 'A' at 0/0: one-cycle write, ready low exactly one cycle
        push(10'd0, 4'b0001, 8'h41, TB_COLOR);
        send(8'h41);
        chk("a_ready_low", 32'(bus.char_ready_o), 0);
        chk("a_col", 32'(bus.cursor_col_o), 1);
        @(posedge clk); #1;
        chk("a_ready_back", 32'(bus.char_ready_o), 1);

        // Move to row 2 col 0, fill 6 chars, then 'B' at idx 166
        send(8'h0D);
        send(8'h0A);
        send(8'h0A);
        chk("lf2_row", 32'(bus.cursor_row_o), 2);
        push(10'd40, 4'b0001, 8'h61, TB_COLOR);
        push(10'd40, 4'b0010, 8'h62, TB_COLOR);
        push(10'd40, 4'b0100, 8'h63, TB_COLOR);
        push(10'd40, 4'b1000, 8'h64, TB_COLOR);
        push(10'd41, 4'b0001, 8'h65, TB_COLOR);
        push(10'd41, 4'b0010, 8'h66, TB_COLOR);
        s = "abcdef";
        for (int i = 0; i < 6; i++) send(s[i]);
        push(10'd41, 4'b0100, 8'h42, TB_COLOR);
        send(8'h42);
        chk("b_col", 32'(bus.cursor_col_o), 7);
        chk("b_row", 32'(bus.cursor_row_o), 2);

        // Row 3 col 10, then control codes
        send(8'h0A);
        for (int i = 0; i < 10; i++) begin
            push_idx(240 + i, 8'h30 + 8'(i));
            send(8'h30 + 8'(i));
        end
        chk("pre_cr_col", 32'(bus.cursor_col_o), 10);
        send(8'h0D);
        chk("cr_ready", 32'(bus.char_ready_o), 1);
        chk("cr_col", 32'(bus.cursor_col_o), 0);
        chk("cr_row", 32'(bus.cursor_row_o), 3);
        send(8'h0A);
        chk("lf_ready", 32'(bus.char_ready_o), 1);
        chk("lf_row", 32'(bus.cursor_row_o), 4);
        send(8'h08);
        chk("bs0_col", 32'(bus.cursor_col_o), 0);
        push(10'd80, 4'b0001, 8'h78, TB_COLOR);
        send(8'h78);
        send(8'h7F);
        chk("del_col", 32'(bus.cursor_col_o), 1);
        send(8'h08);
        chk("bs1_col", 32'(bus.cursor_col_o), 0);

        // Wrap: row 29 col 79, then 'Z'
        for (int i = 0; i < 25; i++) send(8'h0A);
        chk("row29", 32'(bus.cursor_row_o), 29);
        for (int c = 0; c < 79; c++) begin
            push_idx(2320 + c, 8'h2E);
            send(8'h2E);
        end
        chk("col79", 32'(bus.cursor_col_o), 79);
        push(10'd599, 4'b1000, 8'h5A, TB_COLOR);
        send(8'h5A);
        chk("wrap_col", 32'(bus.cursor_col_o), 0);
        chk("wrap_row", 32'(bus.cursor_row_o), 0);

        // Full clear with a byte held pending during the sweep
        for (int i = 0; i < 600; i++) push(10'(i), 4'hF, 8'h20, 8'h0F);
        push(10'd0, 4'b0001, 8'h51, TB_COLOR);
        send(8'h0A);
        send(8'h0C);
        chk("ff_busy", 32'(bus.busy_o), 1);
        chk("ff_col", 32'(bus.cursor_col_o), 0);
        chk("ff_row", 32'(bus.cursor_row_o), 0);
        bus.char_data_i  = 8'h51;
        bus.char_valid_i = 1'b1;
        cnt = 0;
        @(negedge clk);
        chk("ff_ready_low", 32'(bus.char_ready_o), 0);
        while (bus.busy_o && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        chk("ff_busy_cycles", cnt, 600);
        @(posedge clk);
        #1 bus.char_valid_i = 1'b0;
        chk("q_col", 32'(bus.cursor_col_o), 1);
        repeat (3) @(posedge clk);
        chk("q_drained", exp_q.size(), 0);

        // Reset in the middle of a sweep
        for (int i = 0; i <= 300; i++) push(10'(i), 4'hF, 8'h20, 8'h0F);
        send(8'h0C);
        cnt = 0;
        while (!(bus.char_map_we_o && bus.char_map_addr_o == 10'd300) && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        chk("sweep_reached_300", 32'(cnt < 1000), 1);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (20) @(posedge clk);
        chk("midrst_drained", exp_q.size(), 0);
        push(10'd0, 4'b0001, 8'h43, TB_COLOR);
        send(8'h43);
        repeat (3) @(posedge clk);
        chk("final_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
